// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the streaming FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, SWAP} fir_state_e;

  localparam int MAX_ACC_W = 64;

  function automatic int acc_width(input int data_w, input int coef_w, input int num_taps);
    return data_w + coef_w + $clog2(num_taps);
  endfunction

  // Clamp a sign-extended accumulator into the signed range of an out_w-bit result.
  function automatic logic signed [MAX_ACC_W-1:0] saturate(
    input logic signed [MAX_ACC_W-1:0] value,
    input int out_w
  );
    logic signed [MAX_ACC_W-1:0] hi;
    logic signed [MAX_ACC_W-1:0] lo;
    if (out_w >= MAX_ACC_W) return value;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/fir_if.sv
// Sample stream, result stream and coefficient-programming signals of the FIR filter.
interface fir_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 32,
  parameter int ADDR_W = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     coef_wr_en;
  logic [ADDR_W-1:0]        coef_wr_addr;
  logic signed [COEF_W-1:0] coef_wr_data;
  logic                     coef_commit;
  logic                     coef_busy;

  modport master (
    output in_valid, in_data, out_ready, coef_wr_en, coef_wr_addr, coef_wr_data, coef_commit,
    input  in_ready, out_valid, out_data, coef_busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_wr_en, coef_wr_addr, coef_wr_data, coef_commit,
    output in_ready, out_valid, out_data, coef_busy
  );
endinterface

// File: rtl/fir_coef_bank.sv
// Shadow and active coefficient registers; the active bank only changes on the swap strobe.
module fir_coef_bank #(
  parameter int COEF_W   = 16,
  parameter int NUM_TAPS = 9,
  parameter int ADDR_W   = $clog2(NUM_TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [COEF_W-1:0] wr_data,
  input  logic                     swap,
  output logic signed [COEF_W-1:0] c_active [NUM_TAPS]
);

  logic signed [COEF_W-1:0] c_shadow [NUM_TAPS];
  logic                     addr_ok;

  assign addr_ok = int'(wr_addr) < NUM_TAPS;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAPS; i++) c_shadow[i] <= '0;
    end else if (wr_en && addr_ok) begin
      for (int i = 0; i < NUM_TAPS; i++)
        if (wr_addr == ADDR_W'(i)) c_shadow[i] <= wr_data;
    end
  end

  // A write landing in the swap cycle is not visible here: active copies the old shadow value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAPS; i++) c_active[i] <= '0;
    end else if (swap) begin
      c_active <= c_shadow;
    end
  end

endmodule

// File: rtl/fir_stream_filter.sv
// Streaming FIR filter: delay line, registered products, saturating sum register,
// and a drain-then-swap FSM so each output is computed with exactly one coefficient set.
module fir_stream_filter
  import fir_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int NUM_TAPS = 9,
  parameter int OUT_W    = 32
) (
  input logic  clk,
  input logic  reset,
  fir_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, NUM_TAPS);

  fir_state_e               state_q, state_d;
  logic                     en, in_fire, swap;
  logic                     v1, v2, out_valid_q;
  logic signed [DATA_W-1:0] x        [NUM_TAPS];
  logic signed [PROD_W-1:0] p        [NUM_TAPS];
  logic signed [COEF_W-1:0] c_active [NUM_TAPS];
  logic signed [ACC_W-1:0]  sum;
  logic signed [OUT_W-1:0]  out_next, out_q;

  assign en            = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = reset && en && (state_q == RUN);
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign bus.coef_busy = (state_q != RUN);

  fir_coef_bank #(
    .COEF_W  (COEF_W),
    .NUM_TAPS(NUM_TAPS),
    .ADDR_W  (ADDR_W)
  ) u_coef_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.coef_wr_en),
    .wr_addr (bus.coef_wr_addr),
    .wr_data (bus.coef_wr_data),
    .swap    (swap),
    .c_active(c_active)
  );

  // The delay line only shifts on an accepted sample, so it survives stalls and swaps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAPS; i++) x[i] <= '0;
    end else if (in_fire) begin
      x[0] <= bus.in_data;
      for (int i = 1; i < NUM_TAPS; i++) x[i] <= x[i-1];
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_TAPS; i++) sum += ACC_W'(p[i]);
    if (OUT_W >= ACC_W) out_next = OUT_W'(sum);
    else                out_next = OUT_W'(saturate(64'(sum), OUT_W));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      for (int i = 0; i < NUM_TAPS; i++) p[i] <= '0;
    end else if (en) begin
      v1 <= in_fire;
      for (int i = 0; i < NUM_TAPS; i++) p[i] <= PROD_W'(x[i]) * PROD_W'(c_active[i]);
      v2          <= v1;
      out_q       <= out_next;
      out_valid_q <= v2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Commits arriving outside RUN are dropped; the swap waits for every stage to empty.
  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    unique case (state_q)
      RUN:     if (bus.coef_commit) state_d = DRAIN;
      DRAIN:   if (!v1 && !v2 && !out_valid_q) state_d = SWAP;
      SWAP: begin
        swap    = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_fir_stream_filter.sv
// Directed and randomized bench for fir_stream_filter against a sample-history reference model.
module tb_fir_stream_filter;

  localparam int DATA_W   = 16;
  localparam int COEF_W   = 16;
  localparam int NUM_TAPS = 9;
  localparam int OUT_W    = 32;
  localparam int ADDR_W   = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  longint shadow_m [NUM_TAPS];
  longint active_m [NUM_TAPS];
  longint hist  [$];
  longint exp_q [$];
  longint got_q [$];
  longint imp_coefs [NUM_TAPS] = '{2, -5, 10, -20, 112, -20, 10, -5, 2};

  fir_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

  fir_stream_filter #(
    .DATA_W  (DATA_W),
    .COEF_W  (COEF_W),
    .NUM_TAPS(NUM_TAPS),
    .OUT_W   (OUT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference: a filter output is the coefficient-weighted sum of the last NUM_TAPS accepted samples.
  function automatic longint model_out();
    longint acc = 0;
    longint hi  = (longint'(1) <<< (OUT_W - 1)) - 1;
    longint lo  = -(longint'(1) <<< (OUT_W - 1));
    for (int i = 0; i < hist.size(); i++) acc += hist[i] * active_m[i];
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

  task automatic check_output();
    logic                    in_fire, out_fire, hold;
    logic signed [OUT_W-1:0] pre_data;
    longint                  sample;
    @(negedge clk);
    in_fire  = bus.in_valid && bus.in_ready;
    out_fire = bus.out_valid && bus.out_ready;
    hold     = bus.out_valid && !bus.out_ready;
    pre_data = bus.out_data;
    sample   = longint'(bus.in_data);
    @(posedge clk);
    #1;
    if (in_fire) begin
      hist.push_front(sample);
      if (hist.size() > NUM_TAPS) void'(hist.pop_back());
      exp_q.push_back(model_out());
    end
    if (out_fire) begin
      got_q.push_back(longint'(pre_data));
      check("out_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("out_data", 64'(pre_data), exp_q.pop_front());
    end
    if (hold) begin
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_data", 64'(bus.out_data), 64'(pre_data));
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic signed [DATA_W-1:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    check_output();
  endtask

  task automatic write_coef(input int addr, input logic signed [COEF_W-1:0] data);
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_addr = ADDR_W'(addr);
    bus.coef_wr_data = data;
    apply_stimulus(1'b0, '0, 1'b1);
    bus.coef_wr_en = 1'b0;
    if (addr < NUM_TAPS) shadow_m[addr] = longint'(data);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.out_valid || bus.coef_busy || exp_q.size() != 0) && n < 50) begin
      apply_stimulus(1'b0, '0, 1'b1);
      n++;
    end
    check("idle_pending", 64'(exp_q.size()), 64'd0);
    check("idle_busy", 64'(bus.coef_busy), 64'd0);
  endtask

  task automatic do_commit();
    bus.coef_commit = 1'b1;
    apply_stimulus(1'b0, '0, 1'b1);
    bus.coef_commit = 1'b0;
    active_m = shadow_m;
    wait_idle();
  endtask

  // A unit impulse followed by zeros, with the first-result latency checked on the way.
  task automatic feed_impulse();
    got_q.delete();
    apply_stimulus(1'b1, 16'sd1, 1'b1);
    check("lat_edge1", 64'(bus.out_valid), 64'd0);
    apply_stimulus(1'b1, '0, 1'b1);
    check("lat_edge2", 64'(bus.out_valid), 64'd0);
    apply_stimulus(1'b1, '0, 1'b1);
    check("lat_edge3", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < NUM_TAPS - 2; i++) apply_stimulus(1'b1, '0, 1'b1);
    wait_idle();
    check("impulse_count", 64'(got_q.size()), 64'(NUM_TAPS + 1));
  endtask

  initial begin
    int n;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.out_ready    = 1'b0;
    bus.coef_wr_en   = 1'b0;
    bus.coef_wr_addr = '0;
    bus.coef_wr_data = '0;
    bus.coef_commit  = 1'b0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      shadow_m[i] = 0;
      active_m[i] = 0;
    end

    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_coef_busy", 64'(bus.coef_busy), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] impulse response and commit timing");
    for (int i = 0; i < NUM_TAPS; i++) write_coef(i, COEF_W'(imp_coefs[i]));
    bus.coef_commit = 1'b1;
    apply_stimulus(1'b0, '0, 1'b1);
    active_m = shadow_m;
    check("commit_c1_busy", 64'(bus.coef_busy), 64'd1);
    check("commit_c1_in_ready", 64'(bus.in_ready), 64'd0);
    apply_stimulus(1'b0, '0, 1'b1);
    bus.coef_commit = 1'b0;
    check("commit_c2_busy", 64'(bus.coef_busy), 64'd1);
    check("commit_c2_in_ready", 64'(bus.in_ready), 64'd0);
    apply_stimulus(1'b0, '0, 1'b1);
    check("commit_c3_busy", 64'(bus.coef_busy), 64'd0);
    check("commit_c3_in_ready", 64'(bus.in_ready), 64'd1);
    feed_impulse();
    for (int i = 0; i < NUM_TAPS; i++) check($sformatf("impulse[%0d]", i), got_q[i], imp_coefs[i]);
    check("impulse_tail", got_q[NUM_TAPS], 64'd0);

    $display("[TB] out-of-range coefficient writes");
    for (int a = NUM_TAPS; a < 16; a++) write_coef(a, COEF_W'($urandom));
    do_commit();
    feed_impulse();
    for (int i = 0; i < NUM_TAPS; i++) check($sformatf("oor_impulse[%0d]", i), got_q[i], imp_coefs[i]);

    $display("[TB] saturation");
    for (int i = 0; i < NUM_TAPS; i++) write_coef(i, 16'sd32767);
    do_commit();
    got_q.delete();
    for (int i = 0; i < NUM_TAPS; i++) apply_stimulus(1'b1, 16'sd32767, 1'b1);
    wait_idle();
    check("sat_pos", got_q[$], 64'sd2147483647);
    for (int i = 0; i < NUM_TAPS; i++) apply_stimulus(1'b1, -16'sd32768, 1'b1);
    wait_idle();
    check("sat_neg", got_q[$], -64'sd2147483648);

    $display("[TB] random backpressure");
    for (int i = 0; i < NUM_TAPS; i++) write_coef(i, COEF_W'($urandom));
    do_commit();
    for (int i = 0; i < 300; i++)
      apply_stimulus(1'b1, DATA_W'($urandom), 1'($urandom_range(0, 1)));
    wait_idle();

    $display("[TB] commit while streaming");
    for (int i = 0; i < NUM_TAPS; i++) begin
      bus.coef_wr_en   = 1'b1;
      bus.coef_wr_addr = ADDR_W'(i);
      bus.coef_wr_data = COEF_W'($urandom);
      shadow_m[i]      = longint'(bus.coef_wr_data);
      apply_stimulus(1'b1, DATA_W'($urandom), 1'($urandom_range(0, 1)));
    end
    bus.coef_wr_en = 1'b0;
    for (int i = 0; i < 20; i++)
      apply_stimulus(1'b1, DATA_W'($urandom), 1'($urandom_range(0, 1)));
    bus.coef_commit = 1'b1;
    apply_stimulus(1'b1, DATA_W'($urandom), 1'b1);
    active_m = shadow_m;
    check("drain_busy", 64'(bus.coef_busy), 64'd1);
    n = 0;
    while (bus.coef_busy && n < 60) begin
      check("drain_in_ready", 64'(bus.in_ready), 64'd0);
      bus.coef_commit = 1'(n == 0);
      apply_stimulus(1'b1, DATA_W'($urandom), 1'($urandom_range(0, 1)));
      n++;
    end
    bus.coef_commit = 1'b0;
    check("commit_done", 64'(bus.coef_busy), 64'd0);
    for (int i = 0; i < 40; i++)
      apply_stimulus(1'b1, DATA_W'($urandom), 1'($urandom_range(0, 1)));
    wait_idle();

    $display("[TB] asynchronous reset with samples in flight");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, DATA_W'($urandom), 1'b1);
    bus.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_out_data", 64'(bus.out_data), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd0);
    check("arst_coef_busy", 64'(bus.coef_busy), 64'd0);
    hist.delete();
    exp_q.delete();
    for (int i = 0; i < NUM_TAPS; i++) begin
      shadow_m[i] = 0;
      active_m[i] = 0;
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, '0, 1'b1);
      check("arst_no_ghost", 64'(bus.out_valid), 64'd0);
    end
    do_commit();
    feed_impulse();
    for (int i = 0; i <= NUM_TAPS; i++) check($sformatf("arst_impulse[%0d]", i), got_q[i], 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
